// File: rtl/imem_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_unit_if
//  Description : Fetch request/response, program-load and status bundle
//                for the instruction memory fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_fetch_unit_if #(
    parameter int INS_W = 32
);
    logic             req_valid;
    logic [31:0]      req_addr;
    logic             req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [INS_W-1:0] rsp_data;
    logic             rsp_err;
    logic             ld_en;
    logic [31:0]      ld_addr;
    logic [INS_W-1:0] ld_data;
    logic             ld_err;
    logic [31:0]      fetch_cnt;

    // Memory side: accepts requests and loads, produces responses
    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, ld_err, fetch_cnt
    );

    // Requester side: issues fetches and loads, consumes responses
    modport master (
        output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, ld_err, fetch_cnt
    );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_unit
//  Description : Word-addressed instruction memory with a 1-cycle fetch
//                port (valid/ready), a concurrent program-load write port,
//                address fault detection and an accepted-fetch counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_unit #(
    parameter int               INS_ADDRESS = 9,
    parameter int               INS_W       = 32,
    parameter logic [INS_W-1:0] NOP_WORD    = 32'h00000013
) (
    input  wire logic         clk,
    input  wire logic         reset,
    imem_fetch_unit_if.slave  bus
);

    localparam int c_idx_w = INS_ADDRESS - 2;
    localparam int c_depth = 2 ** c_idx_w;

    // Program storage; intentionally never reset
    logic [INS_W-1:0] r_mem [c_depth];

    logic             r_rsp_valid;
    logic [INS_W-1:0] r_rsp_data;
    logic             r_rsp_err;
    logic             r_ld_err;
    logic [31:0]      r_fetch_cnt;

    logic               w_req_fault;
    logic               w_ld_fault;
    logic [c_idx_w-1:0] w_req_idx;
    logic [c_idx_w-1:0] w_ld_idx;
    logic               w_req_ready;
    logic               w_accept;

    // An address is usable only if word aligned and inside the memory window
    assign w_req_fault = (bus.req_addr[1:0] != 2'b00) ||
                         (bus.req_addr[31:INS_ADDRESS] != '0);
    assign w_ld_fault  = (bus.ld_addr[1:0] != 2'b00) ||
                         (bus.ld_addr[31:INS_ADDRESS] != '0);
    assign w_req_idx   = bus.req_addr[INS_ADDRESS-1:2];
    assign w_ld_idx    = bus.ld_addr[INS_ADDRESS-1:2];

    // Ready whenever the output slot is empty or being drained this cycle;
    // forced low directly by the reset level so it drops asynchronously
    assign w_req_ready = reset && (!r_rsp_valid || bus.rsp_ready);
    assign w_accept    = bus.req_valid && w_req_ready;

    // Program-load write; the reset level gates writes issued during reset
    always_ff @(posedge clk) begin
        if (reset && bus.ld_en && !w_ld_fault) begin
            r_mem[w_ld_idx] <= bus.ld_data;
        end
    end

    // Response slot: load on accept, hold while stalled, clear when drained.
    // The read samples pre-write contents, so a same-cycle load is not seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_req_fault;
            r_rsp_data  <= w_req_fault ? NOP_WORD : r_mem[w_req_idx];
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Rejected-load flag lives for exactly the cycle after the bad load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld_err <= 1'b0;
        end else begin
            r_ld_err <= bus.ld_en && w_ld_fault;
        end
    end

    // Accepted-request counter, faulted fetches included; wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_cnt <= '0;
        end else if (w_accept) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.ld_err    = r_ld_err;
    assign bus.fetch_cnt = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_fetch_unit
//  Description : Scoreboard bench for imem_fetch_unit with directed cases
//                and randomized fetch/load traffic against a word-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_unit;

    localparam int          ADDR_BITS = 9;
    localparam int          WORDS     = 128;
    localparam logic [31:0] NOP       = 32'h00000013;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    imem_fetch_unit_if #(.INS_W(32)) bus ();

    imem_fetch_unit #(
        .INS_ADDRESS(ADDR_BITS),
        .INS_W      (32),
        .NOP_WORD   (NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb [$];
    logic [31:0] m_mem [WORDS];
    logic        m_pending = 1'b0;
    logic        m_ld_err  = 1'b0;
    logic [31:0] m_cnt     = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_fault(input logic [31:0] a);
        return (a % 32'd4 != 32'd0) || (a >= 32'd512);
    endfunction

    // Monitor: every presented response must match the oldest expectation
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
            end else begin
                check("rsp_data", 64'(bus.rsp_data), 64'(sb[0].data));
                check("rsp_err",  64'(bus.rsp_err),  64'(sb[0].err));
                if (bus.rsp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic set_idle();
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'd0;
        bus.rsp_ready = 1'b1;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = 32'd0;
        bus.ld_data   = 32'd0;
    endtask

    // One clock of stimulus; the model advances at the negedge after the
    // status outputs of the previous cycle have been compared
    task automatic drive_cycle(input logic rv, input logic [31:0] ra, input logic rdy,
                               input logic le, input logic [31:0] la, input logic [31:0] ldat);
        logic exp_ready;
        exp_t e;
        @(posedge clk);
        #1;
        bus.req_valid = rv;
        bus.req_addr  = ra;
        bus.rsp_ready = rdy;
        bus.ld_en     = le;
        bus.ld_addr   = la;
        bus.ld_data   = ldat;
        @(negedge clk);
        check("ld_err",    64'(bus.ld_err),    64'(m_ld_err));
        check("fetch_cnt", 64'(bus.fetch_cnt), 64'(m_cnt));
        check("rsp_valid", 64'(bus.rsp_valid), 64'(m_pending));
        exp_ready = reset && (!m_pending || rdy);
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        if (exp_ready && rv) begin
            e.err  = is_fault(ra);
            e.data = e.err ? NOP : m_mem[ra / 4];
            sb.push_back(e);
            m_cnt++;
            m_pending = 1'b1;
        end else if (reset && rdy) begin
            m_pending = 1'b0;
        end
        m_ld_err = reset && le && is_fault(la);
        if (reset && le && !is_fault(la)) m_mem[la / 4] = ldat;
    endtask

    task automatic fetch(input logic [31:0] a);
        drive_cycle(1'b1, a, 1'b1, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        drive_cycle(1'b0, 32'd0, 1'b1, 1'b1, a, d);
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic check_zero();
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
        check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
        check("rst_ld_err",    64'(bus.ld_err),    64'd0);
        check("rst_fetch_cnt", 64'(bus.fetch_cnt), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    endtask

    task automatic model_reset();
        sb.delete();
        m_pending = 1'b0;
        m_ld_err  = 1'b0;
        m_cnt     = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        set_idle();
        #1 reset = 1'b0;
        #1 check_zero();
        model_reset();
        // Traffic during reset must be ignored
        drive_cycle(1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 32'hAAAA5555);
        drive_cycle(1'b1, 32'h14, 1'b1, 1'b1, 32'h3,  32'h12345678);
        set_idle();
        reset = 1'b1;

        // Fill memory so every later in-range fetch has a defined value
        for (int i = 0; i < WORDS; i++) load(32'(i * 4), $urandom);

        // Basic load then fetch
        load(32'h10, 32'h00A00093);
        fetch(32'h10);
        idle_cycle();
        check("cnt_after_first", 64'(bus.fetch_cnt), 64'(m_cnt));

        // Faulted fetches: misaligned and out of range
        fetch(32'h12);
        fetch(32'h200);
        idle_cycle();

        // Same-cycle load and fetch return the old word, refetch the new one
        load(32'h20, 32'h11111111);
        drive_cycle(1'b1, 32'h20, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
        fetch(32'h20);
        idle_cycle();

        // Misaligned load is rejected and leaves word 0 alone
        load(32'h3, 32'hCAFEF00D);
        fetch(32'h0);
        idle_cycle();

        // Backpressure: three stalled cycles then streaming
        fetch(32'h4);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 5; i++) fetch(32'(8 + i * 4));
        idle_cycle();
        idle_cycle();

        // Randomized mixed traffic
        for (int i = 0; i < 400; i++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      a = ($urandom_range(0, WORDS - 1) * 4) + $urandom_range(1, 3);
            else if (kind == 1) a = $urandom | 32'h200;
            else                a = $urandom_range(0, WORDS - 1) * 4;
            drive_cycle(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 2) != 0),
                        1'($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 7) == 0) ? ($urandom | 32'h1) : 32'($urandom_range(0, WORDS - 1) * 4),
                        $urandom);
        end
        idle_cycle();
        idle_cycle();
        check("sb_drained", 64'(sb.size()), 64'd0);

        // Reset while a response is waiting
        fetch(32'h40);
        @(posedge clk);
        #1;
        check("pre_reset_valid", 64'(bus.rsp_valid), 64'd1);
        set_idle();
        bus.rsp_ready = 1'b0;
        #1 reset = 1'b0;
        #1 check_zero();
        model_reset();
        drive_cycle(1'b1, 32'h44, 1'b1, 1'b1, 32'h44, 32'h0BADF00D);
        drive_cycle(1'b1, 32'h48, 1'b0, 1'b0, 32'd0, 32'd0);
        set_idle();
        reset = 1'b1;
        idle_cycle();
        idle_cycle();
        fetch(32'h10);
        idle_cycle();
        idle_cycle();
        check("sb_final", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
